// File: rtl/proc_mem_responder_pkg.sv
// proc_mem_responder_pkg: request type constants and address checking shared by
// the memory responder and the processor control.
package proc_mem_responder_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    // A word access is bad when misaligned or past the end of a WORDS-deep array.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] != 2'b00) || (addr >= 32'(4 * words));
    endfunction

endpackage

// File: rtl/proc_mem_responder_mem_resp_pipe.sv
// mem_resp_pipe: optional one-cycle response register; RESP_LAT=0 passes the
// request-cycle response straight through.
module mem_resp_pipe #(
    parameter int RESP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    input  logic [31:0] in_data,
    output logic        out_val,
    output logic [31:0] out_data
);

    logic        val_q;
    logic [31:0] data_q;

    // Data only loads on a response so the last value is held while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q  <= 1'b0;
            data_q <= 32'h0;
        end else begin
            val_q <= in_val;
            if (in_val)
                data_q <= in_data;
        end
    end

    assign out_val  = (RESP_LAT == 0) ? in_val  : val_q;
    assign out_data = (RESP_LAT == 0) ? in_data : data_q;

endmodule

// File: rtl/proc_mem_responder.sv
// proc_mem_responder: word memory answering imem fetches and dmem lw/sw, with a
// loader port that takes priority over both request ports.
module proc_mem_responder
    import proc_mem_responder_pkg::*;
#(
    parameter int WORDS    = 256,
    parameter int RESP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    output logic [31:0] dmemresp_rdata,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        err
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [WORDS];
    logic          i_bad, d_bad, l_bad;
    logic          i_go, d_go, d_wr, we, err_set;
    logic [AW-1:0] i_idx, d_idx, l_idx, w_idx;
    logic [31:0]   w_data, i_rd, d_rd;

    assign i_bad = addr_bad(imemreq_addr, WORDS);
    assign d_bad = addr_bad(dmemreq_addr, WORDS);
    assign l_bad = addr_bad(ld_addr, WORDS);
    assign i_idx = imemreq_addr[AW+1:2];
    assign d_idx = dmemreq_addr[AW+1:2];
    assign l_idx = ld_addr[AW+1:2];

    // The loader owns the cycle: request ports go silent while ld_en is high.
    assign i_go   = imemreq_val & ~ld_en;
    assign d_go   = dmemreq_val & ~ld_en;
    assign d_wr   = d_go & (dmemreq_type == MEMREQ_WRITE) & ~d_bad;
    assign we     = ld_en ? ~l_bad : d_wr;
    assign w_idx  = ld_en ? l_idx : d_idx;
    assign w_data = ld_en ? ld_data : dmemreq_wdata;

    // Reads see the array before this edge's write commits.
    assign i_rd = i_bad ? 32'h0 : mem[i_idx];
    assign d_rd = (d_bad || dmemreq_type == MEMREQ_WRITE) ? 32'h0 : mem[d_idx];

    assign err_set = ld_en ? (dmemreq_val | l_bad)
                           : ((imemreq_val & i_bad) | (dmemreq_val & d_bad));

    always_ff @(posedge clk) begin
        if (we)
            mem[w_idx] <= w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (err_set)
            err <= 1'b1;
    end

    mem_resp_pipe #(.RESP_LAT(RESP_LAT)) u_ipipe (
        .clk     (clk),
        .rst     (rst),
        .in_val  (i_go),
        .in_data (i_rd),
        .out_val (imemresp_val),
        .out_data(imemresp_data)
    );

    mem_resp_pipe #(.RESP_LAT(RESP_LAT)) u_dpipe (
        .clk     (clk),
        .rst     (rst),
        .in_val  (d_go),
        .in_data (d_rd),
        .out_val (dmemresp_val),
        .out_data(dmemresp_rdata)
    );

endmodule
